// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/memory status in, stage enables, kills and counters out.
// The controller takes the slave modport; the pipeline (or a bench) takes master.
// Purely a wiring container, no storage.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hdu_stall;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             err_clr;
  logic             cnt_clr;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             if_kill;
  logic             dec_kill;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  hdu_stall, branch_taken, dmem_req, dmem_ready, err_clr, cnt_clr,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
    output if_kill, dec_kill, mem_err, stall_cnt, flush_cnt
  );

  modport master (
    output hdu_stall, branch_taken, dmem_req, dmem_ready, err_clr, cnt_clr,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
    input  if_kill, dec_kill, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout and saturating perf counters.
// Latency: enables/kills are combinational from state and inputs; state and counters update on the edge.
// Backpressure: a pending data-memory access freezes every stage register until ready or timeout.
module pipe_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Row encoding: {pc, ifid, idex, exmem, memwb, if_kill, dec_kill}
  localparam logic [6:0] ROW_A = 7'b00000_00; // memory stall, freeze everything
  localparam logic [6:0] ROW_B = 7'b11111_11; // taken branch, squash IF/ID and ID/EX
  localparam logic [6:0] ROW_C = 7'b00111_01; // load-use, hold front, bubble into EX
  localparam logic [6:0] ROW_D = 7'b11111_00; // normal advance

  localparam logic [3:0]       TIMEOUT_V = 4'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [6:0]       w_row;
  logic [6:0]       w_resolve_row;
  logic             w_mem_err;

  // Once memory is not blocking, a taken branch wins over load-use since the stalled instruction is wrong-path.
  always_comb begin
    w_resolve_row = ROW_D;
    if (bus.branch_taken)
      w_resolve_row = ROW_B;
    else if (bus.hdu_stall)
      w_resolve_row = ROW_C;
  end

  // Row selection and next-state; reset forces a full freeze with no error flag.
  always_comb begin
    w_row       = ROW_A;
    w_mem_err   = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            w_row       = ROW_A;
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = 4'd1;
          end else begin
            w_row = w_resolve_row;
          end
        end
        ST_WAIT: begin
          if (!bus.dmem_ready) begin
            w_row = ROW_A;
            if (r_wait_cnt == TIMEOUT_V)
              w_state_nxt = ST_ERR;
            else
              w_wait_nxt = r_wait_cnt + 4'd1;
          end else begin
            w_row       = w_resolve_row;
            w_state_nxt = ST_RUN;
            w_wait_nxt  = 4'd0;
          end
        end
        ST_ERR: begin
          w_row     = ROW_A;
          w_mem_err = 1'b1;
          if (bus.err_clr) begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = 4'd0;
          end
        end
        default: begin
          w_row       = ROW_A;
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 4'd0;
        end
      endcase
    end
  end

  // FSM state and memory-wait cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Saturating perf counters; a clear beats a same-cycle increment, FSM transitions never touch them.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_row[6] && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_row[1] && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
          bus.memwb_write, bus.if_kill, bus.dec_kill} = w_row;
  assign bus.mem_err   = w_mem_err;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule
